canvas_uart_dumper: RTL and testbench

- Reads the 640x360, 4-bit-per-pixel canvas RAM through its second read/write port and streams the whole image to a host over UART (8N1), so drawings can be saved.
- Packs two pixels per byte and frames the image with a header byte and an XOR checksum trailer.
- Sits beside the frame buffer on the pixel clock domain. It owns one RAM port during a dump, with write enable held low on that port.

---
 rtl/canvas_uart_dumper.sv | 260 ++++++++++++++++++++++++++
 tb/tb_canvas_uart_dumper.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_uart_dumper.sv
// canvas_uart_dumper
//   Streams the whole 4-bpp canvas out of its second RAM port as an 8N1 UART
//   frame: header byte, N/2 packed data bytes (even pixel in the high nibble),
//   then the XOR of all data bytes. Runs on the pixel clock.
//
// Ports
//   pixel_clk_in  : system clock
//   rst_n_in      : asynchronous active-low reset (aborts a dump in progress)
//   start_in      : one-cycle request to begin a dump (ignored unless idle)
//   addr_out      : linear canvas read address (x + H_PIXELS*y)
//   rd_en_out     : RAM port enable, high only on fetch cycles
//   pixel_data_in : RAM read data, valid RAM_LATENCY cycles after addr_out
//   tx_out        : UART serial line, idle high
//   busy_out      : high from the cycle after start is accepted until done
//   done_out      : one-cycle pulse after the trailer stop bit completes
module canvas_uart_dumper #(
  parameter int         H_PIXELS      = 640,
  parameter int         V_PIXELS      = 360,
  parameter int         CLKS_PER_BAUD = 645,
  parameter int         RAM_LATENCY   = 2,
  parameter logic [7:0] HEADER_BYTE   = 8'hA5
) (
  input  logic                                  pixel_clk_in,
  input  logic                                  rst_n_in,
  input  logic                                  start_in,
  output logic [$clog2(H_PIXELS*V_PIXELS)-1:0]  addr_out,
  output logic                                  rd_en_out,
  input  logic [3:0]                            pixel_data_in,
  output logic                                  tx_out,
  output logic                                  busy_out,
  output logic                                  done_out
);

  localparam int NPIX   = H_PIXELS * V_PIXELS;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int HALF   = NPIX / 2;
  localparam int BYTE_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BAUD_W = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BAUD - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(HALF - 1);
  localparam logic [31:0]       HALF_U    = 32'(HALF);
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_DATA    = 3'd2,
    ST_TRAILER = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  state_t              state_r;
  state_t              next_state_s;

  logic [BAUD_W-1:0]   baud_cnt_r;
  logic [3:0]          bit_idx_r;
  logic [8:0]          shift_r;       // {stop bit, data bits still to send}
  logic [BYTE_W-1:0]   byte_cnt_r;
  logic [7:0]          checksum_r;
  logic [7:0]          next_byte_r;   // prefetched byte waiting to be sent
  logic                fetch_second_r;
  logic [RAM_LATENCY-1:0] fetch_vld_r;
  logic [RAM_LATENCY-1:0] fetch_odd_r;

  logic                accept_s;
  logic                active_s;
  logic                baud_end_s;
  logic                byte_end_s;
  logic                last_byte_s;
  logic                load_data_s;
  logic                fetch_next_s;
  logic [31:0]         fetch_idx_s;

  // Running XOR of data bytes; kept as a helper so the trailer rule is obvious.
  function automatic logic [7:0] checksum_update(input logic [7:0] sum,
                                                 input logic [7:0] data);
    return sum ^ data;
  endfunction

  assign accept_s    = (state_r == ST_IDLE) && start_in;
  assign active_s    = (state_r == ST_HEADER) || (state_r == ST_DATA) ||
                       (state_r == ST_TRAILER);
  assign baud_end_s  = (baud_cnt_r == BAUD_LAST);
  assign byte_end_s  = baud_end_s && (bit_idx_r == STOP_BIT);
  assign last_byte_s = (byte_cnt_r == BYTE_LAST);
  // A data byte is loaded when the header ends or a non-final data byte ends.
  assign load_data_s = byte_end_s &&
                       ((state_r == ST_HEADER) ||
                        ((state_r == ST_DATA) && !last_byte_s));
  assign fetch_next_s = load_data_s && (fetch_idx_s < HALF_U);

  // Index of the byte to prefetch when a data byte starts shifting out.
  always_comb begin
    fetch_idx_s = 32'd0;
    if (state_r == ST_HEADER) begin
      fetch_idx_s = 32'd1;
    end else begin
      fetch_idx_s = 32'(byte_cnt_r) + 32'd2;
    end
  end

  // Next-state logic for the dump sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_in) next_state_s = ST_HEADER;
        else          next_state_s = ST_IDLE;
      end
      ST_HEADER: begin
        if (byte_end_s) next_state_s = ST_DATA;
        else            next_state_s = ST_HEADER;
      end
      ST_DATA: begin
        if (byte_end_s && last_byte_s) next_state_s = ST_TRAILER;
        else                           next_state_s = ST_DATA;
      end
      ST_TRAILER: begin
        if (byte_end_s) next_state_s = ST_FINISH;
        else            next_state_s = ST_TRAILER;
      end
      ST_FINISH: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // UART shifter, baud/bit/byte counters, checksum and status outputs.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_out     <= 1'b1;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_idx_r  <= 4'd0;
      shift_r    <= 9'h1FF;
      byte_cnt_r <= {BYTE_W{1'b0}};
      checksum_r <= 8'h00;
    end else begin
      done_out <= 1'b0;
      if (accept_s) begin
        // Start bit of the header goes out on the very next cycle.
        tx_out     <= 1'b0;
        busy_out   <= 1'b1;
        baud_cnt_r <= {BAUD_W{1'b0}};
        bit_idx_r  <= 4'd0;
        shift_r    <= {1'b1, HEADER_BYTE};
        byte_cnt_r <= {BYTE_W{1'b0}};
        checksum_r <= 8'h00;
      end else if (active_s) begin
        if (!baud_end_s) begin
          baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
        end else begin
          baud_cnt_r <= {BAUD_W{1'b0}};
          if (bit_idx_r != STOP_BIT) begin
            bit_idx_r <= bit_idx_r + 4'd1;
            tx_out    <= shift_r[0];
            shift_r   <= {1'b1, shift_r[8:1]};
          end else if (state_r == ST_TRAILER) begin
            tx_out    <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b1;
            bit_idx_r <= 4'd0;
          end else begin
            // Back-to-back: next start bit directly follows this stop bit.
            tx_out    <= 1'b0;
            bit_idx_r <= 4'd0;
            if (load_data_s) begin
              shift_r    <= {1'b1, next_byte_r};
              checksum_r <= checksum_update(checksum_r, next_byte_r);
              if (state_r == ST_HEADER) begin
                byte_cnt_r <= {BYTE_W{1'b0}};
              end else begin
                byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
              end
            end else begin
              // Last data byte already folded in when it was loaded.
              shift_r <= {1'b1, checksum_r};
            end
          end
        end
      end else begin
        tx_out   <= 1'b1;
        busy_out <= 1'b0;
      end
    end
  end

  // Two-cycle fetch (even then odd pixel) for the byte after the one starting.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_out       <= {ADDR_W{1'b0}};
      rd_en_out      <= 1'b0;
      fetch_second_r <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_out       <= {ADDR_W{1'b0}};
        rd_en_out      <= 1'b1;
        fetch_second_r <= 1'b1;
      end else if (fetch_next_s) begin
        addr_out       <= addr_out + ADDR_W'(1);
        rd_en_out      <= 1'b1;
        fetch_second_r <= 1'b1;
      end else if (fetch_second_r) begin
        addr_out       <= addr_out + ADDR_W'(1);
        rd_en_out      <= 1'b1;
        fetch_second_r <= 1'b0;
      end else begin
        rd_en_out      <= 1'b0;
        fetch_second_r <= 1'b0;
      end
    end
  end

  // Delay line marking which cycle returns read data; address LSB picks nibble.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_vld_r <= {RAM_LATENCY{1'b0}};
      fetch_odd_r <= {RAM_LATENCY{1'b0}};
    end else begin
      for (int i = RAM_LATENCY - 1; i > 0; i--) begin
        fetch_vld_r[i] <= fetch_vld_r[i-1];
        fetch_odd_r[i] <= fetch_odd_r[i-1];
      end
      fetch_vld_r[0] <= rd_en_out;
      fetch_odd_r[0] <= addr_out[0];
    end
  end

  // Capture returned pixels into the prefetch byte.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      next_byte_r <= 8'h00;
    end else begin
      if (fetch_vld_r[RAM_LATENCY-1]) begin
        if (fetch_odd_r[RAM_LATENCY-1]) begin
          next_byte_r[3:0] <= pixel_data_in;
        end else begin
          next_byte_r[7:4] <= pixel_data_in;
        end
      end else begin
        next_byte_r <= next_byte_r;
      end
    end
  end

endmodule

// File: tb/tb_canvas_uart_dumper.sv
module tb_canvas_uart_dumper;

  localparam int S_N      = 8;     // small canvas 4x2
  localparam int S_CPB    = 4;
  localparam int S_BYTES  = 6;
  localparam int S_BITCYC = 10 * S_CPB;
  localparam int B_N      = 96;    // random canvas 16x6
  localparam int B_CPB    = 5;
  localparam int B_BYTES  = B_N / 2 + 2;
  localparam int B_BITCYC = 10 * B_CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s, start_b;
  logic [2:0] addr_s;
  logic [6:0] addr_b;
  logic       rd_en_s, rd_en_b;
  logic [3:0] pix_s, pix_b;
  logic       tx_s, tx_b, busy_s, busy_b, done_s, done_b;

  logic [3:0] mem_s [S_N];
  logic [3:0] mem_b [B_N];
  logic [3:0] ram_s_d1;
  logic [3:0] ram_b_d1, ram_b_d2;
  logic [7:0] exp_frame [S_BYTES];

  int addr_q[$];
  int done_total;
  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  canvas_uart_dumper #(
    .H_PIXELS(4), .V_PIXELS(2), .CLKS_PER_BAUD(S_CPB), .RAM_LATENCY(2),
    .HEADER_BYTE(8'hA5)
  ) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .start_in(start_s),
    .addr_out(addr_s), .rd_en_out(rd_en_s), .pixel_data_in(pix_s),
    .tx_out(tx_s), .busy_out(busy_s), .done_out(done_s)
  );

  canvas_uart_dumper #(
    .H_PIXELS(16), .V_PIXELS(6), .CLKS_PER_BAUD(B_CPB), .RAM_LATENCY(3),
    .HEADER_BYTE(8'hA5)
  ) dut_big (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .start_in(start_b),
    .addr_out(addr_b), .rd_en_out(rd_en_b), .pixel_data_in(pix_b),
    .tx_out(tx_b), .busy_out(busy_b), .done_out(done_b)
  );

  // Latency-2 RAM for the small canvas
  always @(posedge clk) begin
    if (rd_en_s) ram_s_d1 <= mem_s[addr_s];
    pix_s <= ram_s_d1;
  end

  // Latency-3 RAM for the random canvas
  always @(posedge clk) begin
    if (rd_en_b) ram_b_d1 <= mem_b[addr_b];
    ram_b_d2 <= ram_b_d1;
    pix_b    <= ram_b_d2;
  end

  // Record read addresses and done pulses of the small instance
  always @(negedge clk) begin
    if (rd_en_s === 1'b1) addr_q.push_back(int'(addr_s));
    if (done_s === 1'b1) done_total <= done_total + 1;
  end

  // Expected frame straight from the packing rules
  task automatic build_expected();
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    exp_frame[0] = 8'hA5;
    for (int k = 0; k < S_N / 2; k++) begin
      b = {mem_s[2*k], mem_s[2*k+1]};
      exp_frame[k+1] = b;
      x = x ^ b;
    end
    exp_frame[S_BYTES-1] = x;
  endtask

  // Ideal line level t cycles after the first start bit
  function automatic logic exp_level(int t);
    int bi;
    int k;
    logic [7:0] byt;
    bi = t / S_BITCYC;
    k  = (t % S_BITCYC) / S_CPB;
    byt = exp_frame[bi];
    if (k == 0) return 1'b0;
    else if (k == 9) return 1'b1;
    else return byt[k-1];
  endfunction

  task automatic run_small_frame(input string tag, input bit poke_busy, input bit poke_done);
    int q0;
    int d0;
    build_expected();
    q0 = addr_q.size();
    d0 = done_total;
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    for (int t = 0; t < S_BYTES * S_BITCYC; t++) begin
      if (poke_busy && t == 100) start_s = 1'b1;
      if (poke_busy && t == 101) start_s = 1'b0;
      n_checks++;
      if (tx_s !== exp_level(t)) begin
        n_fail++;
        $display("FAIL %s tx t=%0d got %b want %b", tag, t, tx_s, exp_level(t));
      end
      if (t == 0) begin
        n_checks++;
        if (busy_s !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy_rise got %b want 1", tag, busy_s);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_s !== 1'b1 || busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_timing got done=%b busy=%b want done=1 busy=0", tag, done_s, busy_s);
    end
    if (poke_done) start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n_checks++;
    if (done_s !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_width got %b want 0", tag, done_s);
    end
    for (int i = 0; i < 2 * S_CPB; i++) begin
      n_checks++;
      if (tx_s !== 1'b1 || busy_s !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle_after got tx=%b busy=%b want tx=1 busy=0", tag, tx_s, busy_s);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_total - d0 !== 1) begin
      n_fail++;
      $display("FAIL %s done_count got %0d want 1", tag, done_total - d0);
    end
    n_checks++;
    if (addr_q.size() - q0 !== S_N) begin
      n_fail++;
      $display("FAIL %s rd_en_cycles got %0d want %0d", tag, addr_q.size() - q0, S_N);
    end else begin
      for (int i = 0; i < S_N; i++) begin
        n_checks++;
        if (addr_q[q0+i] !== i) begin
          n_fail++;
          $display("FAIL %s addr_seq[%0d] got %0d want %0d", tag, i, addr_q[q0+i], i);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_s = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0 || rd_en_s !== 1'b0 || addr_s !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_small got tx=%b busy=%b done=%b rd_en=%b addr=%0d want 1 0 0 0 0",
               tx_s, busy_s, done_s, rd_en_s, addr_s);
    end
    n_checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0 || rd_en_b !== 1'b0 || addr_b !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_big got tx=%b busy=%b done=%b rd_en=%b addr=%0d want 1 0 0 0 0",
               tx_b, busy_b, done_b, rd_en_b, addr_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < S_N; i++) mem_s[i] = 4'(i + 1);
    run_small_frame("basic", 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < S_N; i++) mem_s[i] = 4'(i + 1);
    run_small_frame("start_busy", 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_dump();
    for (int i = 0; i < S_N; i++) mem_s[i] = 4'(i + 1);
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    repeat (95) @(negedge clk);   // inside byte 0x34
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_s !== 1'b1 || busy_s !== 1'b0 || rd_en_s !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got tx=%b busy=%b rd_en=%b want 1 0 0", tx_s, busy_s, rd_en_s);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_small_frame("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_flat_patterns();
    for (int i = 0; i < S_N; i++) mem_s[i] = 4'hF;
    run_small_frame("all_f", 1'b0, 1'b0);
    for (int i = 0; i < S_N; i++) mem_s[i] = 4'h0;
    run_small_frame("all_0", 1'b0, 1'b0);
  endtask

  task automatic test_random_canvas();
    logic [7:0] rx;
    logic [7:0] rx_q[$];
    logic [7:0] sw_xor;
    int j;
    for (int i = 0; i < B_N; i++) mem_b[i] = 4'($urandom_range(0, 15));
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    rx = 8'h00;
    for (int t = 0; t < B_BYTES * B_BITCYC; t++) begin
      if (t % B_CPB == B_CPB / 2) begin
        j = (t % B_BITCYC) / B_CPB;
        if (j == 0 || j == 9) begin
          n_checks++;
          if (tx_b !== (j == 9)) begin
            n_fail++;
            $display("FAIL rand_framing t=%0d got %b want %b", t, tx_b, (j == 9));
          end
          if (j == 9) rx_q.push_back(rx);
        end else begin
          rx[j-1] = tx_b;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_done got done=%b busy=%b want 1 0", done_b, busy_b);
    end
    n_checks++;
    if (rx_q.size() !== B_BYTES) begin
      n_fail++;
      $display("FAIL rand_count got %0d want %0d", rx_q.size(), B_BYTES);
    end else begin
      n_checks++;
      if (rx_q[0] !== 8'hA5) begin
        n_fail++;
        $display("FAIL rand_header got %h want a5", rx_q[0]);
      end
      sw_xor = 8'h00;
      for (int k = 0; k < B_N / 2; k++) begin
        n_checks++;
        if (rx_q[k+1][7:4] !== mem_b[2*k] || rx_q[k+1][3:0] !== mem_b[2*k+1]) begin
          n_fail++;
          $display("FAIL rand_image byte %0d got %h want %h%h", k, rx_q[k+1], mem_b[2*k], mem_b[2*k+1]);
        end
        sw_xor = sw_xor ^ {mem_b[2*k], mem_b[2*k+1]};
      end
      n_checks++;
      if (rx_q[B_BYTES-1] !== sw_xor) begin
        n_fail++;
        $display("FAIL rand_trailer got %h want %h", rx_q[B_BYTES-1], sw_xor);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    done_total = 0;
    test_reset();
    test_basic_frame();
    test_start_while_busy();
    test_reset_mid_dump();
    test_flat_patterns();
    test_random_canvas();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
